// File: rtl/fir_output_packer.sv
// Output stage for fir_filter_symmetric: round/shift, saturate, buffer in a
// show-ahead FIFO and present on valid/ready with a per-frame last marker.
module fir_output_packer #(
    parameter int IN_W      = 18,
    parameter int OUT_W     = 8,
    parameter int SHIFT     = 2,
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  y_in,
    input  logic             y_valid,
    output logic [OUT_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [7:0]       sat_cnt,
    output logic [7:0]       drop_cnt
);

    localparam int PW  = $clog2(DEPTH);
    localparam int FW  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [IN_W:0]  RND   = (SHIFT > 0) ? ((IN_W+1)'(1) << RSH) : '0;
    localparam logic [IN_W:0]  MAXV  = (IN_W+1)'((2 ** OUT_W) - 1);
    localparam logic [PW:0]    FULL  = (PW+1)'(DEPTH);
    localparam logic [FW-1:0]  FLAST = FW'(FRAME_LEN - 1);

    logic [IN_W:0]    rsum;
    logic [IN_W:0]    rsh;
    logic             sat;

    logic             s1_valid;
    logic [OUT_W-1:0] s1_data;

    logic [OUT_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      occ;
    logic [FW-1:0]    fcnt;

    logic             pop;
    logic             push;
    logic             drop;
    logic [PW-1:0]    rd_next;
    logic [PW:0]      occ_next;
    logic [FW-1:0]    fcnt_next;
    logic [OUT_W-1:0] head_next;

    // Extra top bit keeps the rounding carry of an all-ones input.
    always_comb begin
        rsum = {1'b0, y_in} + RND;
        rsh  = rsum >> SHIFT;
        sat  = (rsh > MAXV);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            sat_cnt  <= '0;
        end else begin
            s1_valid <= y_valid;
            s1_data  <= sat ? {OUT_W{1'b1}} : rsh[OUT_W-1:0];
            if (y_valid && sat && (sat_cnt != 8'hFF))
                sat_cnt <= sat_cnt + 8'd1;
        end
    end

    always_comb begin
        pop       = m_valid & m_ready;
        push      = s1_valid & ((occ != FULL) | pop);
        drop      = s1_valid & ~push;
        rd_next   = pop ? rd_ptr + 1'b1 : rd_ptr;
        occ_next  = occ;
        if (push && !pop)
            occ_next = occ + 1'b1;
        else if (pop && !push)
            occ_next = occ - 1'b1;
        fcnt_next = fcnt;
        if (pop)
            fcnt_next = (fcnt == FLAST) ? '0 : fcnt + 1'b1;
        // New head is the incoming sample only when it lands in the slot the
        // read pointer moves to (i.e. the FIFO would otherwise be empty).
        head_next = (push && (wr_ptr == rd_next)) ? s1_data : mem[rd_next];
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s1_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            fcnt     <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_data   <= '0;
            drop_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr  <= rd_next;
            occ     <= occ_next;
            fcnt    <= fcnt_next;
            m_valid <= (occ_next != '0);
            m_last  <= (occ_next != '0) && (fcnt_next == FLAST);
            m_data  <= head_next;
            if (drop && (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: doc/fir_output_packer.md
Name: fir_output_packer

Overview:
- Downstream stage of fir_filter_symmetric. It consumes the filter's 18-bit unsigned y_out stream, one sample per enabled cycle.
- Each sample is scaled by a right shift with round-half-up, then saturated to OUT_W bits.
- Results are buffered in a small FIFO and presented on a valid/ready output with a per-frame last marker.
- The filter has no backpressure, so this block absorbs stalls and counts the samples it has to drop.

Parameters:
- IN_W, 18, input sample width; matches the filter's y_out.
- OUT_W, 8, output sample width.
- SHIFT, 2, right-shift amount, 0..IN_W-1.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- FRAME_LEN, 16, output samples per frame; at least 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low: the block resets on a clk edge where rst=0.
- y_in  in  IN_W  filter output sample, unsigned.
- y_valid  in  1  y_in is valid this cycle.
- m_data  out  OUT_W  output sample at the FIFO head.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  consumer accepts m_data.
- m_last  out  1  current output is the last sample of a frame.
- sat_cnt  out  8  count of saturated samples; sticks at 255.
- drop_cnt  out  8  count of dropped samples; sticks at 255.

Behaviour:
- Reset (edge with rst=0):
  - pipeline valid cleared, FIFO empty, frame counter 0;
  - m_valid=0, m_last=0, m_data=0, sat_cnt=0, drop_cnt=0.
  - Any in-flight or stored samples are discarded. Reset mid-frame restarts the frame at 0.
- Stage 1, registered, always advances and never stalls:
  - r = (y_in + R) >> SHIFT, computed in IN_W+1 bits. R = 2^(SHIFT-1) when SHIFT>0, and R = 0 when SHIFT=0.
  - If r > 2^OUT_W-1, the stored value is 2^OUT_W-1 and sat_cnt increments (saturating).
  - The stage-1 valid bit is y_valid delayed by one cycle.
- Stage 2, FIFO write:
  - A valid stage-1 result is written at the next edge when occupancy < DEPTH, or when a pop happens on the same edge.
  - Otherwise the sample is discarded and drop_cnt increments (saturating).
  - Pop on the same edge as push with the FIFO full: occupancy stays at DEPTH and nothing is dropped.
  - Push with the FIFO empty: no bypass; the sample becomes visible the next cycle.
- Latency: y_valid high in cycle N gives m_valid high in cycle N+2, provided the FIFO was empty and the sample was not dropped.
- Output:
  - Show-ahead FIFO: m_valid = (occupancy != 0) and m_data = head entry; both are driven from registers.
  - Handshake = m_valid & m_ready; a pop happens only on a handshake.
  - m_data must hold stable while m_valid=1 and m_ready=0.
  - m_ready is ignored when m_valid=0.
- Frame counter fcnt:
  - Range 0..FRAME_LEN-1; increments on each handshake and wraps to 0 after FRAME_LEN-1.
  - m_last = m_valid & (fcnt == FRAME_LEN-1).
  - Dropped samples do not advance fcnt.
- Counters: sat_cnt and drop_cnt each increment by at most 1 per cycle and never wrap; both clear only on reset.
- FIFO pointers: log2(DEPTH) bits wide, wrap naturally; occupancy is tracked in a separate counter of width log2(DEPTH)+1.

Test Plan:
- Impulse through the filter with coefficients [10 20 30 40 30 20 10], m_ready=1, SHIFT=2:
  - m_data sequence 3,5,8,10,8,5,3;
  - zero input gives m_data=0 samples;
  - first m_valid appears 2 cycles after the filter presents 10;
  - sat_cnt=0 and drop_cnt=0 at the end.
- Rounding, SHIFT=2, direct drive:
  - y_in=5 → 1, y_in=6 → 2, y_in=0 → 0, y_in=2 → 1.
- Saturation: y_in=18'h3FFFF, then y_in=1023.
  - Outputs 255 then 255 (1023+2=1025, >>2 = 256, which saturates).
  - sat_cnt=2.
- Backpressure, m_ready=0, six consecutive valid samples 1..6 at SHIFT=0:
  - occupancy stops at 4 and drop_cnt=2;
  - m_data holds at 1;
  - after raising m_ready, outputs are 1,2,3,4, then m_valid=0.
- Full-plus-simultaneous pop, FIFO full, m_ready=1, y_valid continuous:
  - occupancy stays 4, drop_cnt unchanged;
  - output order preserved.
- Frames and reset, FRAME_LEN=4, 8 handshakes:
  - m_last=1 only on handshakes 4 and 8.
  - Then fill 3 entries, pulse rst=0 for one edge: m_valid=0, fcnt=0 and both counters 0 in the following cycle.
  - The next frame's 4th sample asserts m_last.
